// File: rtl/common.sv
// Shared CNF formula types for the DPLL SAT solver datapath.
// Literal = {var[2:0], pol}; var 0 marks an empty literal slot.
package common;
    typedef logic [3:0] lit_t;

    localparam lit_t ZERO_LIT = 4'b0000;

    typedef struct packed {
        lit_t [4:0] lits;
        logic [2:0] count;
    } clause_t;

    typedef struct packed {
        clause_t [9:0] clauses;
        logic [3:0]    count;
    } formula_t;
endpackage

// File: rtl/unit_clause.sv
// Unit-clause detector: scans a latched formula one clause per cycle and
// reports the first clause with exactly one live literal.
module unit_clause
    import common::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     find,
    input  formula_t in_formula,
    output logic     ended,
    output logic     found,
    output lit_t     lit_found
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t   state_q, state_d;
    formula_t form_q, form_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic     ended_q, ended_d;
    logic     found_q, found_d;
    lit_t     lit_q, lit_d;
    clause_t  cur_clause;

    function automatic logic [3:0] clamp_count(input logic [3:0] c);
        return (c > 4'd10) ? 4'd10 : c;
    endfunction

    // Lowest-index slot with a non-zero variable wins; empty clause gives ZERO_LIT.
    function automatic lit_t first_live(input clause_t c);
        lit_t r;
        r = ZERO_LIT;
        for (int i = 4; i >= 0; i--) begin
            if (c.lits[i][3:1] != 3'd0) r = c.lits[i];
        end
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        form_d     = form_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        ended_d    = ended_q;
        found_d    = found_q;
        lit_d      = lit_q;
        cur_clause = form_q.clauses[idx_q];

        case (state_q)
            IDLE: begin
                if (find) begin
                    form_d  = in_formula;
                    cnt_d   = clamp_count(in_formula.count);
                    idx_d   = 4'd0;
                    ended_d = 1'b0;
                    found_d = 1'b0;
                    lit_d   = ZERO_LIT;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (cnt_q == 4'd0) begin
                    ended_d = 1'b1;
                    found_d = 1'b0;
                    lit_d   = ZERO_LIT;
                    state_d = DONE;
                end else if (cur_clause.count == 3'd1) begin
                    ended_d = 1'b1;
                    found_d = 1'b1;
                    lit_d   = first_live(cur_clause);
                    state_d = DONE;
                end else if (idx_q == cnt_q - 4'd1) begin
                    ended_d = 1'b1;
                    found_d = 1'b0;
                    lit_d   = ZERO_LIT;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            DONE: begin
                if (!find) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ended_q <= 1'b0;
            found_q <= 1'b0;
            lit_q   <= ZERO_LIT;
        end else begin
            state_q <= state_d;
            ended_q <= ended_d;
            found_q <= found_d;
            lit_q   <= lit_d;
        end
    end

    // Scan copy and index are only meaningful in SCAN, so they carry no reset.
    always_ff @(posedge clock) begin
        form_q <= form_d;
        idx_q  <= idx_d;
        cnt_q  <= cnt_d;
    end

    assign ended     = ended_q;
    assign found     = found_q;
    assign lit_found = lit_q;

endmodule

// File: tb/tb_unit_clause.sv
// Directed bench for unit_clause: hand-built formulas with hand-computed
// scan latency, found flag and reported literal.
module tb_unit_clause;
    import common::*;

    logic     clock;
    logic     reset;
    logic     find;
    formula_t in_formula;
    logic     ended;
    logic     found;
    lit_t     lit_found;

    int n_checks = 0;
    int n_errors = 0;

    unit_clause dut (
        .clock      (clock),
        .reset      (reset),
        .find       (find),
        .in_formula (in_formula),
        .ended      (ended),
        .found      (found),
        .lit_found  (lit_found)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic clause_t cl(input logic [2:0] cnt, input lit_t a, input lit_t b);
        clause_t c;
        c = '0;
        c.count   = cnt;
        c.lits[0] = a;
        c.lits[1] = b;
        return c;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Starts a search from IDLE, scrambles in_formula during the scan, then
    // checks latency, result, hold behaviour and returns to IDLE.
    task automatic run(input string name, input formula_t f, input int exp_lat,
                       input logic exp_found, input lit_t exp_lit);
        int n;
        in_formula = f;
        find       = 1'b1;
        tick();
        chk({name, "_start_ended"}, ended, 0);
        in_formula = '0;
        n = 0;
        while (!ended && n < 15) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, exp_lat);
        chk({name, "_found"}, found, exp_found);
        chk({name, "_lit"}, lit_found, exp_lit);
        tick();
        tick();
        chk({name, "_hold_ended"}, ended, 1);
        chk({name, "_hold_lit"}, {found, lit_found}, {exp_found, exp_lit});
        find = 1'b0;
        tick();
    endtask

    formula_t f10, fu0, fnone, fcut, fzero, fclamp, fmal, fslot;

    initial begin
        reset      = 1'b1;
        find       = 1'b1;
        in_formula = '0;

        // clauses 0..8 are binary, clause 9 unit with its literal in slot 2
        f10 = '0;
        for (int i = 0; i < 9; i++) f10.clauses[i] = cl(3'd2, 4'b0011, 4'b0100);
        f10.clauses[9].count   = 3'd1;
        f10.clauses[9].lits[2] = 4'b0110;
        f10.count = 4'd10;

        fu0 = '0;
        fu0.clauses[0] = cl(3'd1, 4'b1011, 4'b0000);
        fu0.clauses[1] = cl(3'd1, 4'b0100, 4'b0000);
        fu0.count = 4'd2;

        fnone = '0;
        fnone.clauses[0] = cl(3'd2, 4'b0011, 4'b0101);
        fnone.clauses[1] = cl(3'd3, 4'b0011, 4'b0101);
        fnone.clauses[2] = cl(3'd5, 4'b0011, 4'b0101);
        fnone.count = 4'd3;

        fcut = '0;
        for (int i = 0; i < 4; i++) fcut.clauses[i] = cl(3'd2, 4'b0010, 4'b0111);
        fcut.clauses[4] = cl(3'd1, 4'b1101, 4'b0000);
        fcut.count = 4'd4;

        fzero = '0;
        fzero.clauses[0] = cl(3'd1, 4'b1011, 4'b0000);
        fzero.count = 4'd0;

        fclamp = '0;
        fclamp.clauses[9] = cl(3'd1, 4'b1111, 4'b0000);
        fclamp.count = 4'd15;

        fmal = '0;
        fmal.clauses[0] = cl(3'd3, 4'b0011, 4'b0101);
        fmal.clauses[1] = cl(3'd3, 4'b0011, 4'b0101);
        fmal.clauses[2].count = 3'd1;
        fmal.count = 4'd3;

        fslot = '0;
        fslot.clauses[1].count   = 3'd1;
        fslot.clauses[1].lits[4] = 4'b1001;
        fslot.count = 4'd2;

        tick();
        tick();
        chk("reset_ended", ended, 0);
        chk("reset_found", found, 0);
        chk("reset_lit", lit_found, ZERO_LIT);
        reset = 1'b0;
        find  = 1'b0;
        tick();

        run("last_unit", f10, 10, 1'b1, 4'b0110);
        run("first_unit", fu0, 1, 1'b1, 4'b1011);
        run("no_unit", fnone, 3, 1'b0, ZERO_LIT);
        run("count_cut", fcut, 4, 1'b0, ZERO_LIT);
        run("count_zero", fzero, 1, 1'b0, ZERO_LIT);
        run("count_clamp", fclamp, 10, 1'b1, 4'b1111);
        run("malformed", fmal, 3, 1'b1, ZERO_LIT);
        run("high_slot", fslot, 2, 1'b1, 4'b1001);

        // reset in the middle of a scan, then a fresh search from IDLE
        in_formula = f10;
        find = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("midscan_busy", ended, 0);
        reset = 1'b1;
        in_formula = fu0;
        tick();
        chk("midscan_rst", {ended, found, lit_found}, {1'b0, 1'b0, ZERO_LIT});
        reset = 1'b0;
        tick();
        tick();
        chk("after_rst_ended", ended, 1);
        chk("after_rst_result", {found, lit_found}, {1'b1, 4'b1011});
        find = 1'b0;
        tick();

        run("restart", fnone, 3, 1'b0, ZERO_LIT);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
